// File: rtl/mips_boot_pkg.sv
// Shared definitions for the MIPS boot loader: FSM state encoding and header length.
// CKSUM exists only when BOOT_CKSUM_EN is defined.
package mips_boot_pkg;

  localparam int HDR_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
`ifdef BOOT_CKSUM_EN
    CKSUM = 3'd3,
`endif
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/mips_boot_asm.sv
// Big-endian byte-to-word assembler. o_word_done pulses combinationally with the
// fourth accepted byte, and o_word then carries the complete word.
module mips_boot_asm (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_done
);

  logic [23:0] r_part;
  logic [1:0]  r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_part <= '0;
      r_cnt  <= '0;
    end else if (i_en) begin
      r_part <= {r_part[15:0], i_byte};
      r_cnt  <= r_cnt + 2'd1;
    end
  end

  assign o_word      = {r_part, i_byte};
  assign o_word_done = i_en && (r_cnt == 2'd3);

endmodule

// File: rtl/mips_boot_loader.sv
// Byte-stream boot loader: parses a start/count header and writes words to memory,
// then releases the CPU. Define BOOT_CKSUM_EN to require a trailing XOR checksum byte.
module mips_boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int HDR_BYTES = mips_boot_pkg::HDR_BYTES
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              load_err
);
  import mips_boot_pkg::*;

  // state | meaning
  // IDLE  | waiting for header byte 0
  // HDR   | collecting header bytes 1..HDR_BYTES-1
  // DATA  | assembling words; r_fin marks the final write cycle
  // CKSUM | expecting the XOR trailer byte
  // DONE  | load complete, CPU released
  // ERR   | load aborted

  localparam logic [16:0] MEM_WORDS = 17'd1 << ADDR_W;
`ifdef BOOT_CKSUM_EN
  localparam state_t POST_DATA = CKSUM;
`else
  localparam state_t POST_DATA = DONE;
`endif

  state_t      r_state, w_state_nxt;
  logic [31:0] r_hdr;
  logic [7:0]  r_hdr_cnt;
  logic [15:0] r_idx;
  logic        r_fin;
  logic        r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic        w_ready, w_acc, w_hdr_last, w_hdr_bad;
  logic        w_asm_en, w_asm_clr, w_word_done;
  logic [31:0] w_hdr_next, w_word;
  logic [15:0] w_addr_full;
  logic        w_unused;

  assign w_acc       = in_valid && w_ready && !restart;
  assign w_hdr_next  = {r_hdr[23:0], in_data};
  assign w_hdr_last  = (r_hdr_cnt == 8'(HDR_BYTES - 1));
  // 17-bit sum so a header that runs past the top of memory cannot wrap into range
  assign w_hdr_bad   = ({1'b0, w_hdr_next[31:16]} + {1'b0, w_hdr_next[15:0]}) > MEM_WORDS;
  assign w_addr_full = r_hdr[31:16] + r_idx;
  assign w_unused    = ^w_addr_full[15:ADDR_W];
  assign w_asm_en    = w_acc && (r_state == DATA);
  assign w_asm_clr   = restart || (r_state != DATA);

  mips_boot_asm u_asm (
    .i_clk       (clk1),
    .i_rst_n     (rst_n),
    .i_clr       (w_asm_clr),
    .i_en        (w_asm_en),
    .i_byte      (in_data),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

`ifdef BOOT_CKSUM_EN
  logic [7:0] r_xor;

  always_ff @(posedge clk1) begin
    if (!rst_n || restart)
      r_xor <= '0;
    else if (w_acc && (r_state != CKSUM))
      r_xor <= r_xor ^ in_data;
  end
`endif

  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      IDLE, HDR: w_ready = 1'b1;
      DATA:      w_ready = !r_fin;
`ifdef BOOT_CKSUM_EN
      CKSUM:     w_ready = 1'b1;
`endif
      default:   w_ready = 1'b0;
    endcase
    if (!rst_n) w_ready = 1'b0;
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_acc) w_state_nxt = HDR;
      HDR: begin
        if (w_acc && w_hdr_last) begin
          if (w_hdr_bad)                    w_state_nxt = ERR;
          else if (w_hdr_next[15:0] == '0)  w_state_nxt = POST_DATA;
          else                              w_state_nxt = DATA;
        end
      end
      DATA: if (r_fin) w_state_nxt = POST_DATA;
`ifdef BOOT_CKSUM_EN
      CKSUM: if (w_acc) w_state_nxt = (in_data == r_xor) ? DONE : ERR;
`endif
      default: w_state_nxt = r_state;
    endcase
    if (restart) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk1) begin
    if (!rst_n || restart) begin
      r_hdr       <= '0;
      r_hdr_cnt   <= '0;
      r_idx       <= '0;
      r_fin       <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= w_word_done;
      if (w_acc && ((r_state == IDLE) || (r_state == HDR))) begin
        r_hdr     <= w_hdr_next;
        r_hdr_cnt <= r_hdr_cnt + 8'd1;
      end
      if (w_word_done) begin
        r_mem_wdata <= w_word;
        r_mem_addr  <= w_addr_full[ADDR_W-1:0];
        r_idx       <= r_idx + 16'd1;
        if (r_idx == (r_hdr[15:0] - 16'd1)) r_fin <= 1'b1;
      end else begin
        r_fin <= 1'b0;
      end
    end
  end

  assign in_ready  = w_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_run   = (r_state == DONE);
  assign load_err  = (r_state == ERR);

endmodule

// File: tb/tb_mips_boot_loader.sv
// Scoreboard bench for mips_boot_loader: expected writes are queued by the stimulus
// and popped by a negedge monitor whenever mem_we is seen.
module tb_mips_boot_loader;
  localparam int ADDR_W = 10;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk1 = 1'b0;
  logic              rst_n, in_valid, in_ready, restart;
  logic [7:0]        in_data;
  logic              mem_we, cpu_run, load_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  int  n_checks = 0;
  int  n_errors = 0;
  int  n_wr     = 0;
  wr_t exp_q[$];
  logic prev_we = 1'b0;
`ifdef BOOT_CKSUM_EN
  logic [7:0] ck_flip = 8'h00;
`endif

  always #5 clk1 = ~clk1;

  mips_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .restart   (restart),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_run   (cpu_run),
    .load_err  (load_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk1) begin
    wr_t e;
    if (mem_we === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(mem_addr), 32'(e.addr));
        check("write_data", mem_wdata, e.data);
      end
      if (prev_we) begin
        n_checks++;
        n_errors++;
        $display("FAIL double_strobe: got mem_we high two cycles in a row, expected single pulse");
      end
    end
    prev_we = (mem_we === 1'b1);
  end

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rs);
    int n;
    n = 0;
    @(negedge clk1);
    in_valid = 1'b1;
    in_data  = b;
    restart  = rs;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk1);
      n++;
    end
    if (n >= 40) begin
      n_checks++;
      n_errors++;
      $display("FAIL in_ready_timeout: got in_ready=%b for 40 cycles, expected 1", in_ready);
    end
    @(posedge clk1);
    #1;
    in_valid = 1'b0;
    restart  = 1'b0;
  endtask

  task automatic send_stream(input byte_q_t s, input int gap);
`ifdef BOOT_CKSUM_EN
    logic [7:0] x;
    x = 8'h00;
`endif
    foreach (s[i]) begin
      repeat (gap) @(negedge clk1);
      send_byte(s[i], 1'b0);
`ifdef BOOT_CKSUM_EN
      x = x ^ s[i];
`endif
    end
`ifdef BOOT_CKSUM_EN
    send_byte(x ^ ck_flip, 1'b0);
`endif
  endtask

  task automatic pulse_restart();
    @(negedge clk1);
    restart = 1'b1;
    @(posedge clk1);
    #1;
    restart = 1'b0;
  endtask

  task automatic finish_check(input string name);
    repeat (3) @(negedge clk1);
    check({name, "_cpu_run"}, cpu_run, 1);
    check({name, "_load_err"}, load_err, 0);
    check({name, "_in_ready"}, in_ready, 0);
    check({name, "_writes_seen"}, exp_q.size(), 0);
  endtask

  initial begin
    byte_q_t s;
    int wr_before;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; restart = 1'b0;
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_run", cpu_run, 0);
    check("rst_load_err", load_err, 0);
    rst_n = 1'b1;
    @(negedge clk1);
    check("idle_in_ready", in_ready, 1);

    // single word at address 0
    push_wr(0, 32'h28010078);
    s = {8'h00, 8'h00, 8'h00, 8'h01, 8'h28, 8'h01, 8'h00, 8'h78};
    send_stream(s, 0);
`ifndef BOOT_CKSUM_EN
    @(negedge clk1);
    check("a_strobe", mem_we, 1);
    check("a_run_during_write", cpu_run, 0);
    @(negedge clk1);
    check("a_run_after_write", cpu_run, 1);
    check("a_we_low_done", mem_we, 0);
`endif
    finish_check("a");
    pulse_restart();
    @(negedge clk1);
    check("restart_cpu_run", cpu_run, 0);
    check("restart_in_ready", in_ready, 1);

    // two words at 120 with valid gaps
    push_wr(120, 32'h00000055);
    push_wr(121, 32'h000000AA);
    s = {8'h00, 8'h78, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'hAA};
    send_stream(s, 2);
    finish_check("b");

    // overflowing header 1020+8 > 1024
    pulse_restart();
    wr_before = n_wr;
    s = {8'h03, 8'hFC, 8'h00, 8'h08};
    foreach (s[i]) send_byte(s[i], 1'b0);
    repeat (3) @(negedge clk1);
    check("c_load_err", load_err, 1);
    check("c_cpu_run", cpu_run, 0);
    check("c_in_ready", in_ready, 0);
    check("c_no_writes", n_wr - wr_before, 0);

    // exact fit at the top of memory: 1022+2 == 1024
    pulse_restart();
    push_wr(1022, 32'h01020304);
    push_wr(1023, 32'h05060708);
    s = {8'h03, 8'hFE, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_stream(s, 0);
    finish_check("f");

    // zero-count header
    pulse_restart();
    s = {8'h00, 8'h10, 8'h00, 8'h00};
    send_stream(s, 0);
    finish_check("g");

    // reset in the middle of a word
    pulse_restart();
    s = {8'h00, 8'h05, 8'h00, 8'h01, 8'hAB, 8'hCD};
    foreach (s[i]) send_byte(s[i], 1'b0);
    wr_before = n_wr;
    @(negedge clk1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk1);
    check("d_no_stale_write", n_wr - wr_before, 0);
    check("d_idle_ready", in_ready, 1);
    push_wr(6, 32'h11223344);
    s = {8'h00, 8'h06, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send_stream(s, 1);
    finish_check("d");

    // restart coincident with the completing byte discards it
    pulse_restart();
    s = {8'h00, 8'h10, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03};
    foreach (s[i]) send_byte(s[i], 1'b0);
    wr_before = n_wr;
    send_byte(8'h04, 1'b1);
    repeat (3) @(negedge clk1);
    check("e_discard_no_write", n_wr - wr_before, 0);
    check("e_idle_ready", in_ready, 1);
    check("e_cpu_run", cpu_run, 0);
    push_wr(16, 32'hAABBCCDD);
    s = {8'h00, 8'h10, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_stream(s, 0);
    finish_check("e");

`ifdef BOOT_CKSUM_EN
    // corrupted trailer aborts, then a clean load succeeds
    pulse_restart();
    push_wr(0, 32'hDEADBEEF);
    ck_flip = 8'h01;
    s = {8'h00, 8'h00, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_stream(s, 0);
    ck_flip = 8'h00;
    repeat (3) @(negedge clk1);
    check("h_bad_ck_err", load_err, 1);
    check("h_bad_ck_run", cpu_run, 0);
    pulse_restart();
    push_wr(2, 32'h01020304);
    s = {8'h00, 8'h02, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    send_stream(s, 0);
    finish_check("h");
`endif

    repeat (3) @(negedge clk1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion after 500000 time units, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips_boot_loader.md
MIPS_BOOT_LOADER -- requirements
Module: mips_boot_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width of target memory.
REQ-002 SHALL have parameter HDR_BYTES, default 4, meaning header length in bytes (2 start address, 2 word count).
REQ-003 SHALL have port clk1  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  byte-stream data valid.
REQ-006 SHALL have port in_ready  output  1  loader accepts byte this cycle.
REQ-007 SHALL have port in_data  input  8  stream byte.
REQ-008 SHALL have port restart  input  1  one-cycle pulse; begin a new load.
REQ-009 SHALL have port mem_we  output  1  memory write strobe, one cycle per word.
REQ-010 SHALL have port mem_addr  output  ADDR_W  memory word address.
REQ-011 SHALL have port mem_wdata  output  32  memory write word.
REQ-012 SHALL have port cpu_run  output  1  CPU released: PC=0, HALTED=0, TAKEN_BRANCH=0 may be applied.
REQ-013 SHALL have port load_err  output  1  load aborted.

Function
REQ-014 A byte SHALL transfer only on a cycle where in_valid and in_ready are both 1.
REQ-015 SHALL use states IDLE, HDR, DATA, CKSUM, DONE, ERR.
REQ-016 IDLE: in_ready=1; first accepted byte -> HDR, counted as header byte 0.
REQ-017 HDR: header is big-endian start[15:0], then count[15:0]; after byte 3: count==0 -> DONE (or CKSUM if enabled); else -> DATA.
REQ-018 HDR exit SHALL go to ERR if start+count > 2**ADDR_W (17-bit compare, no wrap).
REQ-019 DATA: bytes assemble big-endian; on the 4th byte of a word, mem_we=1 next cycle with mem_addr=start+index and mem_wdata=the assembled word.
REQ-020 mem_we SHALL never be 1 for more than one consecutive cycle per word; in_ready stays 1 in DATA (back-to-back bytes allowed).
REQ-021 After the last word's write cycle, -> DONE (or CKSUM if enabled).
REQ-022 DONE: in_ready=0, cpu_run=1 held, mem_we=0.
REQ-023 ERR: in_ready=0, load_err=1 held, cpu_run=0, no writes.
REQ-024 restart in any state SHALL return to IDLE next cycle, clearing cpu_run, load_err, counters and the assembly register; restart together with a byte handshake SHALL discard that byte.
REQ-025 An in_valid gap mid-word SHALL preserve the partial word indefinitely.

Reset
REQ-026 rst_n==0 at a clock edge SHALL force IDLE with in_ready=0 during reset, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, load_err=0.
REQ-027 Reset mid-DATA SHALL suppress any pending write; no mem_we appears in the cycle after reset deasserts.

Configuration
REQ-028 Macro BOOT_CKSUM_EN defined: after the last data byte, CKSUM accepts one byte; it SHALL equal the XOR of all header and data bytes, else -> ERR; match -> DONE.
REQ-029 BOOT_CKSUM_EN undefined: CKSUM state and XOR register SHALL be absent; transitions go directly to DONE.

Structure
REQ-030 Shared package mips_boot_pkg SHALL hold the state encoding and the HDR_BYTES constant; ADDR_W stays a module parameter.
REQ-031 Sub-module mips_boot_asm (byte-to-word big-endian assembler with byte counter and word_done pulse) SHALL be used; all else flat.

Verification
REQ-032 Stream 00 00 00 01 28 01 00 78 -> one mem_we, mem_addr=0, mem_wdata=0x28010078; cpu_run=1 the cycle after.
REQ-033 Header start=120, count=2, words 0x00000055, 0x000000AA with in_valid gaps -> writes at 120 then 121; no extra strobes.
REQ-034 Header start=1020, count=8 (ADDR_W=10) -> load_err=1, zero mem_we, in_ready=0.
REQ-035 rst_n low after 2 data bytes, then new stream of count=1 -> only the new word written; no stale write.
REQ-036 BOOT_CKSUM_EN: correct trailer -> cpu_run=1; trailer XORed with 0x01 -> load_err=1, cpu_run=0; restart then valid stream -> cpu_run=1.
